// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// The converter takes one value through a valid/ready handshake. It runs IN_W
// shift cycles, then holds the packed BCD result until the consumer accepts it.
// Inputs >= 10^DIGITS are flagged on ovf and give bcd = 0.
// Optional feature macro: BIN2BCD_BLANK_EN enables the leading-zero blank mask.
// When the macro is undefined, blank is tied to zero.
module bin2bcd_seq #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + IN_W;
  localparam int CNT_W  = $clog2(IN_W + 1);

  // 10^n evaluated at elaboration; 10^8 still fits in 32 bits
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] LIMIT = pow10(DIGITS);
  // When every IN_W-bit value fits in the digits, overflow can never happen
  localparam logic OVF_POSSIBLE = ((32'd1 << IN_W) > LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  logic [WORK_W-1:0]    r_work;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_lat;
  logic                 r_out_valid;
  logic [BCD_W-1:0]     r_bcd;
  logic                 r_ovf;

  logic [WORK_W-1:0]    w_adj;
  logic [WORK_W-1:0]    w_next;
  logic [BCD_W-1:0]     w_res;
  logic                 w_ovf_in;
  logic                 w_last;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign ovf       = r_ovf;

  assign w_ovf_in = OVF_POSSIBLE && (32'(bin) >= LIMIT);
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CNT_W'(IN_W - 1));
  // The result is taken from the post-shift value so that it is ready on the last shift edge
  assign w_res    = r_ovf_lat ? '0 : w_next[WORK_W-1 -: BCD_W];

  // Add 3 to every BCD nibble >= 5 (all in parallel), then shift the register left by one
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[IN_W + 4*d +: 4] >= 4'd5)
        w_adj[IN_W + 4*d +: 4] = r_work[IN_W + 4*d +: 4] + 4'd3;
    end
    w_next = w_adj << 1;
  end

  // Control FSM with the working register, the shift counter and the registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_ovf_lat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work    <= {{BCD_W{1'b0}}, bin};
            r_cnt     <= '0;
            r_ovf_lat <= w_ovf_in;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_bcd       <= w_res;
            r_ovf       <= r_ovf_lat;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_next;
  logic              w_zero_run;

  // Blank digit i when it and every digit above it are zero. Units are never blanked, and nothing is blanked on overflow
  always_comb begin
    w_zero_run   = 1'b1;
    w_blank_next = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero_run      = w_zero_run && (w_res[4*i +: 4] == 4'd0);
      w_blank_next[i] = w_zero_run && !r_ovf_lat;
    end
  end

  // Blank mask is registered together with bcd on the final shift edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_blank <= '0;
    else if (w_last) r_blank <= w_blank_next;
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

endmodule
